uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmit line between NUM_REQ byte sources (e.g. button-triggered
//  and status senders). Round-robin arbitration, byte latch, baud timing, 8N1 framing.
//  Sits between the request/control logic and the board TX pin.
//  Replaces per-source load/transmit handshakes with a single sequencer.
// PARAMETERS
//  NUM_REQ    4            number of requesters (>=2)
//  DATA_BITS  8            payload bits per frame, LSB first
//  CLK_FREQ   100_000_000  clk frequency, Hz
//  BAUD       9600         line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >=2)
// PORTS
//  clk       in   1                  system clock, all logic on posedge
//  reset     in   1                  synchronous, active-high
//  req       in   NUM_REQ            level request per source; held with data until gnt
//  data_in   in   NUM_REQ*DATA_BITS  flattened bytes; source i at [i*DATA_BITS +: DATA_BITS]
//  gnt       out  NUM_REQ            one-hot, one-cycle pulse: byte of that source accepted
//  grant_id  out  $clog2(NUM_REQ)    index of source owning the current/last frame
//  busy      out  1                  high from frame start to end of stop bit
//  tx_out    out  1                  serial line, idle high
// BEHAVIOUR
//  - Reset values: tx_out=1, busy=0, gnt=0, grant_id=0, rr pointer so source 0 has top priority.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP. Each non-IDLE state lasts exactly
//    CLKS_PER_BIT cycles, timed by the baud counter. The counter is cleared on each state entry.
//  - IDLE: tx_out=1, busy=0. If any req bit is set, pick the first set bit searching from
//    last_grant+1 upward and wrapping. Latch its data into the shift register.
//    Next cycle: state=START, gnt[i]=1 for that one cycle, grant_id=i, busy=1, tx_out=0.
//  - DATA: shift LSB first, DATA_BITS bits, with a bit counter 0..DATA_BITS-1.
//  - STOP: tx_out=1. After its last cycle go to IDLE.
//  - IDLE lasts at least 1 cycle between frames, so back-to-back frames have one extra
//    high cycle.
//  - Frame length: (2+DATA_BITS[+1]) * CLKS_PER_BIT cycles, from gnt pulse to IDLE re-entry.
//  - req or data_in changing mid-frame: ignored. Latched byte is unaffected.
//  - req dropped before grant: that request is withdrawn, with no error.
//  - Only one gnt bit is ever set at a time. gnt never pulses outside the IDLE->START edge.
//  - reset asserted mid-frame: frame abandoned. On the next edge all outputs take their
//    reset values (tx_out=1 immediately) and the rr pointer resets.
//  - Single requester continuously asserting: served every frame, with no starvation of
//    others (RR).
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN defined: adds PARITY state after DATA.
//    tx_out = ^latched_byte (even parity). Frame = 3+DATA_BITS bits.
//  - Macro UART_TX_PARITY_EN absent: no PARITY state, 8N1 frame of 2+DATA_BITS bits.
//  - The state encoding has no unreachable states in either build.
// STRUCTURE
//  - Package uart_pkg:
//    - typedef enum logic [2:0] tx_sched_state_t {IDLE,START,DATA,PARITY,STOP}
//    - function clks_per_bit(clk_freq, baud)
//    - localparam DEFAULT_DATA_BITS = 8
//  - Sub-module uart_rr_arbiter (NUM_REQ):
//    - combinational first-set-from-pointer search
//    - outputs a valid flag and an index
//    - the pointer register stays in the scheduler
//  - Top: FSM, baud counter, bit counter, shift register, gnt/grant_id registers.
// TESTING (bench: CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16, DATA_BITS=8)
//  1. Reset 3 cycles, no req -> tx_out=1, busy=0, gnt=0 throughout 200 cycles.
//  2. req=4'b0001, data0=8'hA5 -> gnt=0001 one cycle; tx_out low 16 cycles, then
//     1,0,1,0,0,1,0,1 (16 each), then high 16 cycles; busy high 160 cycles.
//  3. req=4'b1111 held, distinct bytes -> gnt order 0,1,2,3,0; grant_id matches.
//     Consecutive frames start 161 cycles apart.
//  4. Grant to src2 done, then req=4'b0101 -> next gnt=0001 (wrap past pointer 2).
//  5. reset pulsed at cycle 70 of a frame -> tx_out=1, busy=0 next edge.
//     req=4'b0010 then served first, with no stale gnt.
//  6. UART_TX_PARITY_EN, data=8'h07 -> parity bit 1 after data.
//     Frame 176 cycles, busy high 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    // The PARITY encoding exists only in the parity build, so neither build
    // carries a state that can never be entered.
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_sched_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } tx_sched_state_t;
`endif

    // Clock cycles per serial bit. Integer divide; the caller must keep it >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin search: first set request bit strictly after the
// pointer, wrapping around. The pointer register itself lives in the caller.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between NUM_REQ byte sources: round-robin grant,
// byte latch, baud timing and 8N1 framing in a single sequencer.
// Optional feature macro: UART_TX_PARITY_EN (START, DATA, PARITY, STOP frame).
//
// Handshake: a source raises req[i] with its byte on data_in and holds both
// until it sees gnt[i] high for one cycle; the byte was latched on the edge
// that raised gnt[i]. Dropping req[i] before that edge withdraws the request.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           tx_out,
    output logic [2:0]                     state_dbg
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    // Pointer at the last source makes source 0 the first candidate.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

    tx_sched_state_t        state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [IDX_W-1:0]       last_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [IDX_W-1:0]       grant_id_q;
    logic                   busy_q;
    logic                   tx_q;
`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`endif

    logic                   arb_valid_d;
    logic [IDX_W-1:0]       arb_idx_d;
    logic [DATA_BITS-1:0]   sel_byte_d;
    logic                   bit_end_d;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (last_q),
        .valid_o (arb_valid_d),
        .idx_o   (arb_idx_d)
    );

    // Pick the winning source's byte out of the flattened data bus.
    always_comb begin
        sel_byte_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_d == IDX_W'(i)) begin
                sel_byte_d = data_in[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign bit_end_d = (cnt_q == CNT_LAST);

    // Frame sequencer: every non-idle state holds for CLKS_PER_BIT cycles,
    // outputs are registered and change only on state boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            last_q     <= PTR_RESET;
            gnt_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (arb_valid_d) begin
                        state_q    <= START;
                        shift_q    <= sel_byte_d;
`ifdef UART_TX_PARITY_EN
                        par_q      <= ^sel_byte_d;
`endif
                        gnt_q      <= NUM_REQ'(1) << arb_idx_d;
                        grant_id_q <= arb_idx_d;
                        last_q     <= arb_idx_d;
                        busy_q     <= 1'b1;
                        tx_q       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_d) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_d) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end_d) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign tx_out    = tx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// Honours UART_TX_PARITY_EN when compiled with it.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            reset;
  logic [NR-1:0]   req;
  logic [7:0]      src_data [NR];
  logic [NR*DB-1:0] data_in;
  logic [NR-1:0]   gnt;
  logic [1:0]      grant_id;
  logic            busy;
  logic            tx_out;
  logic [2:0]      state_dbg;

  assign data_in = {src_data[3], src_data[2], src_data[1], src_data[0]};

  uart_tx_scheduler #(
    .NUM_REQ   (NR),
    .DATA_BITS (DB),
    .CLK_FREQ  (16),
    .BAUD      (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx_out    (tx_out),
    .state_dbg (state_dbg)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];
  int last_m = NR - 1;
  int last_gnt_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: round-robin choice and the serial bit list of a frame
  function automatic int rr_pick(input int last, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic build_frame(input logic [7:0] b);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    last_m = NR - 1;
    last_gnt_cyc = -1;
  endtask

  // Wait for the predicted grant and check the whole frame cycle by cycle.
  // At j==8 all source bytes are scrambled (must not affect the latched byte);
  // with do_mid, req becomes mid_req at j==8 and post_req at j==100.
  task automatic serve(input logic [NR-1:0] mid_req, input logic [NR-1:0] post_req,
                       input bit do_mid, input bit chk_gap, input int abort_at);
    int exp_src;
    int waited;
    int stray;
    logic [7:0] b;
    exp_src = rr_pick(last_m, req);
    waited = 0;
    stray = 0;
    while (gnt === '0 && waited < 400) begin
      step();
      waited++;
    end
    check("gnt_seen", {31'b0, gnt !== '0}, 32'd1);
    if (gnt === '0) return;
    check("gnt_onehot", gnt, 32'd1 << exp_src);
    check("grant_id", grant_id, exp_src);
    if (chk_gap && last_gnt_cyc >= 0) check("frame_spacing", cyc - last_gnt_cyc, FRAME + 1);
    last_gnt_cyc = cyc;
    last_m = exp_src;
    b = src_data[exp_src];
    build_frame(b);
    for (int j = 0; j < FRAME; j++) begin
      if (abort_at > 0 && j == abort_at) begin
        reset = 1'b1;
        step();
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_grant_id", grant_id, 0);
        reset = 1'b0;
        last_m = NR - 1;
        last_gnt_cyc = -1;
        return;
      end
      check("tx_bit", tx_out, exp_q[j / CPB]);
      check("busy_frame", busy, 1);
      if (j > 0 && gnt !== '0) stray++;
      if (j == 8) begin
        for (int k = 0; k < NR; k++) src_data[k] = 8'($urandom);
        if (do_mid) req = mid_req;
      end
      if (j == 100 && do_mid) req = post_req;
      step();
    end
    check("gnt_single_pulse", stray, 0);
    check("busy_end", busy, 0);
    check("tx_idle_end", tx_out, 1);
  endtask

  initial begin
    int bad;
    logic [NR-1:0] m;
    logic [NR-1:0] p;
    reset = 1'b1;
    req = '0;
    for (int k = 0; k < NR; k++) src_data[k] = 8'h00;

    // 1: reset state and a long quiet idle
    do_reset();
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_state", state_dbg, IDLE);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_out !== 1'b1 || busy !== 1'b0 || gnt !== '0) bad++;
      step();
    end
    check("idle_quiet", bad, 0);

    // 2: single byte A5 from source 0, request dropped after grant
    src_data[0] = 8'hA5;
    req = 4'b0001;
    serve(4'b0000, 4'b0000, 1'b1, 1'b0, 0);

    // 3: all sources requesting from a fresh pointer
    do_reset();
    for (int k = 0; k < NR; k++) src_data[k] = 8'($urandom);
    req = 4'b1111;
    for (int f = 0; f < 4; f++) serve(4'b1111, 4'b1111, 1'b0, 1'b1, 0);
    serve(4'b1111, 4'b0100, 1'b1, 1'b1, 0);

    // 4: source 2 served, then 0101 wraps past the pointer to source 0
    serve(4'b0100, 4'b0101, 1'b1, 1'b1, 0);
    serve(4'b0000, 4'b0000, 1'b1, 1'b1, 0);

    // random request patterns, including bits raised and withdrawn mid-frame
    req = 4'($urandom_range(1, 15));
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(0, 15));
      p = (r == 5) ? 4'b0000 : 4'($urandom_range(1, 15));
      serve(m, p, 1'b1, r > 0, 0);
    end

    // parity-relevant byte
    src_data[3] = 8'h07;
    req = 4'b1000;
    serve(4'b0000, 4'b0000, 1'b1, 1'b0, 0);

    // 5: reset in the middle of a frame, then a fresh request
    req = 4'b0100;
    serve(4'b0100, 4'b0100, 1'b0, 1'b0, 70);
    req = 4'b0010;
    serve(4'b0000, 4'b0000, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
